// File: rtl/kpn_fifo_channel_pkg.sv
// Shared definitions for KPN channels and process nodes.
// Tokens are 12.4 fixed point: [15:4] integer part, [3:0] decimal digit 0..9.
package kpn_fifo_channel_pkg;

    localparam int FIX_W     = 16;
    localparam int FIX_INT_W = 12;
    localparam int FIX_DEC_W = 4;

    localparam logic [FIX_DEC_W-1:0] DEC_MAX  = 4'd9;
    localparam logic [FIX_W-1:0]     KPN_ZERO = 16'h0000;

    typedef logic [FIX_W-1:0] fix_t;

    function automatic logic fix_legal(input fix_t v);
        return v[FIX_DEC_W-1:0] <= DEC_MAX;
    endfunction

endpackage

// File: rtl/kpn_fifo_channel_mem.sv
// Token storage for a KPN channel: one write port, one registered read port.
// Reset reloads the preloaded tokens used to prime feedback loops.
module kpn_fifo_channel_mem
    import kpn_fifo_channel_pkg::*;
#(
    parameter int   DEPTH      = 8,
    parameter int   ADDR_W     = 3,
    parameter int   INIT_COUNT = 0,
    parameter fix_t INIT_VALUE = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  fix_t              wr_data,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_addr,
    output fix_t              rd_data
);

    fix_t mem [DEPTH];

    // A read and write to the same slot in one cycle returns the old token.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= (i < INIT_COUNT) ? INIT_VALUE : KPN_ZERO;
            end
            rd_data <= KPN_ZERO;
        end else begin
            if (we) begin
                mem[wr_addr] <= wr_data;
            end
            if (re) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/kpn_fifo_channel.sv
// KPN channel FIFO: responder side of the rd/wr strobe interface.
// Nodes gate their strobes on empty/full to get blocking-read semantics.
module kpn_fifo_channel
    import kpn_fifo_channel_pkg::*;
#(
    parameter int   DEPTH      = 8,
    parameter int   ADDR_W     = 3,
    parameter int   INIT_COUNT = 0,
    parameter fix_t INIT_VALUE = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [FIX_W-1:0]  data_in,
    input  logic              rd,
    output logic [FIX_W-1:0]  data_out,
    output logic              data_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic              fmt_err
);

    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   CNT_INIT = (ADDR_W+1)'(INIT_COUNT);
    localparam logic [ADDR_W-1:0] WP_INIT  = ADDR_W'(INIT_COUNT % DEPTH);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              fmt_ok;
    logic              rd_acc;
    logic              wr_acc;

    assign empty  = (count == '0);
    assign full   = (count == CNT_FULL);
    assign fmt_ok = fix_legal(data_in);
    assign rd_acc = rd && !empty;
    // A read in the same cycle frees a slot, so a full channel still accepts.
    assign wr_acc = wr && fmt_ok && (!full || rd_acc);

    kpn_fifo_channel_mem #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .INIT_COUNT (INIT_COUNT),
        .INIT_VALUE (INIT_VALUE)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .re      (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= WP_INIT;
            rd_ptr     <= '0;
            count      <= CNT_INIT;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
            fmt_err    <= 1'b0;
        end else begin
            data_valid <= rd_acc;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
            if (wr && fmt_ok && full && !rd_acc) begin
                overflow <= 1'b1;
            end
            if (rd && empty) begin
                underflow <= 1'b1;
            end
            if (wr && !fmt_ok) begin
                fmt_err <= 1'b1;
            end
        end
    end

endmodule
